// File: rtl/turfio_cin_align_multi.sv
// turfio_cin_align_multi: per-lane nibble-to-word deserializer and aligner for
// TURFIO CIN links. Each lane collects 4-bit nibbles into a bit window, cuts
// W-bit words at a slip-selected bit offset, and runs a training search that
// slips until TRAIN_PATTERN is seen LOCK_COUNT times in a row.
//
// Ports:
//   aclk_i, rst_i      clock, synchronous active-high reset
//   cin_i              lane n nibble at [4n+3:4n], bit 3 oldest
//   cin_valid_i        nibble qualifier shared by all lanes
//   lock_req_i         per-lane start/restart of the alignment search
//   lock_rst_i         per-lane force to UNLOCKED
//   bitslip_i          per-lane manual one-bit slip
//   auto_align_i       allow automatic slipping while searching
//   train_chk_i        count non-pattern words while locked
//   parallel_o         aligned words, lane n at [W*n+W-1:W*n]
//   parallel_valid_o   per-lane word strobe (locked lanes only)
//   locked_o           per-lane LOCKED indication
//   running_o          all lanes locked
//   fail_o             sticky: full slip sweep ended without lock
//   slip_pos_o         per-lane slip position
//   errcnt_o           per-lane saturating training error count
module turfio_cin_align_multi #(
  parameter int unsigned          NLANE         = 1,
  parameter int unsigned          NIBBLES       = 8,
  parameter logic [4*NIBBLES-1:0] TRAIN_PATTERN = 32'hA55A6996,
  parameter int unsigned          LOCK_COUNT    = 16,
  parameter int unsigned          ERRCNT_WIDTH  = 16
) (
  input  logic                                  aclk_i,
  input  logic                                  rst_i,
  input  logic [4*NLANE-1:0]                    cin_i,
  input  logic                                  cin_valid_i,
  input  logic [NLANE-1:0]                      lock_req_i,
  input  logic [NLANE-1:0]                      lock_rst_i,
  input  logic [NLANE-1:0]                      bitslip_i,
  input  logic                                  auto_align_i,
  input  logic                                  train_chk_i,
  output logic [4*NIBBLES*NLANE-1:0]            parallel_o,
  output logic [NLANE-1:0]                      parallel_valid_o,
  output logic [NLANE-1:0]                      locked_o,
  output logic                                  running_o,
  output logic [NLANE-1:0]                      fail_o,
  output logic [NLANE*$clog2(4*NIBBLES)-1:0]    slip_pos_o,
  output logic [NLANE*ERRCNT_WIDTH-1:0]         errcnt_o
);

  localparam int unsigned W   = 4 * NIBBLES;
  localparam int unsigned PW  = $clog2(W);
  localparam int unsigned PHW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned MCW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned SCW = $clog2(W + 1);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_SEARCH, ST_LOCKED} state_e;

  logic [NLANE-1:0] locked_c;
  logic             running_q;

  for (genvar n = 0; n < NLANE; n++) begin : g_lane
    state_e                  state_q;
    logic [W+3:0]            win_q;
    logic [W+3:0]            win_d;
    logic [PHW-1:0]          phase_q;
    logic                    hold_q;
    logic [PW-1:0]           p_q;
    logic [MCW-1:0]          match_q;
    logic [SCW-1:0]          sweep_q;
    logic [ERRCNT_WIDTH-1:0] err_q;
    logic                    fail_q;
    logic [W-1:0]            par_q;
    logic                    pvalid_q;
    logic [W-1:0]            word_c;
    logic                    bnd_c;
    logic                    hit_c;
    logic                    man_slip_c;
    logic                    auto_slip_c;

    // Window includes the nibble arriving this cycle, so a boundary word
    // ends with the boundary nibble when the bit offset is zero.
    assign win_d  = {win_q[W-1:0], cin_i[4*n +: 4]};
    assign word_c = win_d[p_q[1:0] +: W];
    assign bnd_c  = cin_valid_i && (phase_q == PHW'(NIBBLES - 1));
    assign hit_c  = (word_c == TRAIN_PATTERN);

    assign man_slip_c  = bitslip_i[n] && (state_q != ST_LOCKED) && !lock_rst_i[n];
    assign auto_slip_c = (state_q == ST_SEARCH) && bnd_c && !hit_c && auto_align_i &&
                         !lock_rst_i[n] && !lock_req_i[n];

    // Lane datapath, slip control and alignment FSM.
    always_ff @(posedge aclk_i) begin
      if (rst_i) begin
        state_q  <= ST_UNLOCKED;
        win_q    <= '0;
        phase_q  <= '0;
        hold_q   <= 1'b0;
        p_q      <= '0;
        match_q  <= '0;
        sweep_q  <= '0;
        err_q    <= '0;
        fail_q   <= 1'b0;
        par_q    <= '0;
        pvalid_q <= 1'b0;
      end else begin
        if (cin_valid_i) begin
          win_q <= win_d;
          if (hold_q)                              hold_q  <= 1'b0;
          else if (phase_q == PHW'(NIBBLES - 1))   phase_q <= '0;
          else                                     phase_q <= phase_q + PHW'(1);
        end

        if (bnd_c) par_q <= word_c;
        pvalid_q <= bnd_c && (state_q == ST_LOCKED);

        // Offset wrapping 3->0 moves the word boundary one nibble later.
        if (man_slip_c || auto_slip_c) begin
          p_q <= (p_q == PW'(W - 1)) ? '0 : p_q + PW'(1);
          if (p_q[1:0] == 2'd3) hold_q <= 1'b1;
        end

        if (lock_rst_i[n]) begin
          state_q <= ST_UNLOCKED;
        end else if (lock_req_i[n]) begin
          state_q <= ST_SEARCH;
          match_q <= '0;
          sweep_q <= '0;
          err_q   <= '0;
          fail_q  <= 1'b0;
        end else begin
          unique case (state_q)
            ST_SEARCH: begin
              if (bnd_c) begin
                if (hit_c) begin
                  if (!man_slip_c) begin
                    match_q <= match_q + MCW'(1);
                    if (match_q == MCW'(LOCK_COUNT - 1)) state_q <= ST_LOCKED;
                  end
                end else begin
                  match_q <= '0;
                  if (auto_align_i) begin
                    sweep_q <= sweep_q + SCW'(1);
                    if (sweep_q == SCW'(W - 1)) begin
                      state_q <= ST_UNLOCKED;
                      fail_q  <= 1'b1;
                    end
                  end
                end
              end
            end
            ST_LOCKED: begin
              if (bnd_c && train_chk_i && !hit_c && (err_q != '1))
                err_q <= err_q + ERRCNT_WIDTH'(1);
            end
            default: ;
          endcase
          if (man_slip_c) match_q <= '0;
        end
      end
    end

    assign locked_c[n]                           = (state_q == ST_LOCKED);
    assign parallel_o[W*n +: W]                  = par_q;
    assign parallel_valid_o[n]                   = pvalid_q;
    assign fail_o[n]                             = fail_q;
    assign slip_pos_o[PW*n +: PW]                = p_q;
    assign errcnt_o[ERRCNT_WIDTH*n +: ERRCNT_WIDTH] = err_q;
  end

  // All-lanes-locked flag, one cycle behind the lane states.
  always_ff @(posedge aclk_i) begin
    if (rst_i) running_q <= 1'b0;
    else       running_q <= &locked_c;
  end

  assign locked_o  = locked_c;
  assign running_o = running_q;

endmodule
